ysyx_23060061_wbu: RTL and testbench
====================================

Name: ysyx_23060061_wbu

Overview:
Writeback unit sitting directly upstream of the register file. Holds one completed instruction from the EXU/LSU in a single-entry buffer and selects and shapes the writeback value (ALU, load, PC+4, CSR). Drives the register file write port and emits a commit handshake to the commit/difftest logic. Maintains the retired-instruction counter.

Parameters:
ADDR_WIDTH, 5, register index width; must equal the register file's address width
DATA_WIDTH, 32, datapath width; must be 32, since load shaping assumes RV32

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous reset, active-high
in_valid  input  1  upstream holds a completed instruction
in_ready  output  1  WBU can accept this cycle
in_pc  input  32  instruction PC
in_rd  input  ADDR_WIDTH  destination register
in_wb_en  input  1  instruction writes rd
in_wb_sel  input  2  source select: 0 ALU, 1 LOAD, 2 PC+4, 3 CSR
in_alu_res  input  DATA_WIDTH  ALU result; the effective address for loads
in_load_raw  input  DATA_WIDTH  word-aligned 32-bit memory read data
in_funct3  input  3  load funct3
in_csr_rdata  input  DATA_WIDTH  CSR old value
rf_wen  output  1  register file write enable
rf_waddr  output  ADDR_WIDTH  register file write index
rf_wdata  output  DATA_WIDTH  register file write data
commit_valid  output  1  buffered instruction is ready to retire
commit_ready  input  1  commit consumer accepts
commit_pc  output  32  PC of retiring instruction
commit_exc  output  1  retiring instruction took a load-misaligned or illegal-load fault
retire_cnt  output  64  count of non-faulting retired instructions

Behaviour:
- Internal state: full flag, plus a registered payload holding all in_* fields except in_valid.
- Reset values (rst high at posedge):
  - full=0, retire_cnt=0, payload=0.
  - Hence commit_valid=0, rf_wen=0, rf_waddr=0, rf_wdata=0, commit_pc=0, commit_exc=0, in_ready=1.
- Handshakes:
  - fire_in = in_valid & in_ready.
  - fire_out = commit_valid & commit_ready.
  - in_ready = !full | commit_ready. This is a combinational path from commit_ready.
  - commit_valid = full.
- Buffer update at posedge:
  - fire_in: load payload, full<=1 (covers simultaneous fire_in and fire_out).
  - fire_out without fire_in: full<=0.
  - Neither: hold.
- Latency: an instruction accepted at edge N presents commit_valid during cycle N+1. Throughput is 1/cycle while commit_ready stays high.
- Stall: while commit_ready=0, payload and all outputs hold stable, and in_ready=0 if full.
- rf_waddr = buffered rd. rf_wdata = shaped value. Both are combinational from the payload.
- rf_wen = full & commit_ready & wb_en & (rd!=0) & !commit_exc.
  - Exactly one RF write per instruction, in its fire_out cycle.
  - Never writes x0.
- Value select:
  - sel 0: alu_res.
  - sel 2: pc+4, mod 2^32.
  - sel 3: csr_rdata.
- Load shaping (sel 1), with off = alu_res[1:0]:
  - 000 LB: byte raw[8*off+7 : 8*off], sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH / 101 LHU: half raw[16*off[1]+15 : 16*off[1]], sign/zero-extended. Requires off[0]=0.
  - 010 LW: raw. Requires off=00.
- commit_exc = full & sel==1 & (misaligned | funct3 in {011,110,111}).
  - A faulting instruction still commits (commit_valid handshake).
  - It writes nothing and does not increment retire_cnt.
- retire_cnt increments by 1 on fire_out & !commit_exc. Wraps modulo 2^64.
- rf_wdata when rf_wen=0: shaped value, don't-care to the register file. Bench checks it only when rf_wen=1.
- rst mid-operation: a buffered entry is discarded (no RF write, no commit), and the counter clears. An in_valid present in the reset cycle is not accepted.

Test Plan:
- ALU writeback: sel=0, rd=5, alu_res=0x1234, commit_ready=1 -> next cycle rf_wen=1, waddr=5, wdata=0x1234, commit_pc=in_pc, retire_cnt 0->1.
- Load shaping: raw=0x80FF7F01. LB off=3 -> 0xFFFFFF80. LBU off=1 -> 0x7F. LH off=2 -> 0xFFFF80FF. LHU off=2 -> 0x80FF. LW off=0 -> 0x80FF7F01.
- Faults: LW off=2; LH off=1; funct3=011 -> commit_valid=1, commit_exc=1, rf_wen=0, retire_cnt unchanged.
- x0 and PC+4: rd=0, sel=0 -> rf_wen=0, retire_cnt+1. sel=2, pc=0xFFFFFFFC, rd=1 -> wdata=0x00000000.
- Backpressure: two back-to-back instrs with commit_ready=0 for 3 cycles -> first held stable, in_ready=0, no RF write. When commit_ready rises -> first retires and second is accepted the same cycle, retiring next cycle. Exactly 2 RF writes in order.
- Reset mid-stall: full buffer, rst=1 for one cycle -> commit_valid=0, retire_cnt=0, no rf_wen pulse, in_ready=1 after reset.

Source files
------------

// File: rtl/ysyx_23060061_wbu.sv
// Writeback unit: single-entry buffer between EXU/LSU and the register file.
// Shapes the writeback value, drives the RF write port and the commit handshake.
module ysyx_23060061_wbu #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           in_pc,
   input  logic [ADDR_WIDTH-1:0] in_rd,
   input  logic                  in_wb_en,
   input  logic [1:0]            in_wb_sel,
   input  logic [DATA_WIDTH-1:0] in_alu_res,
   input  logic [DATA_WIDTH-1:0] in_load_raw,
   input  logic [2:0]            in_funct3,
   input  logic [DATA_WIDTH-1:0] in_csr_rdata,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic                  commit_valid,
   input  logic                  commit_ready,
   output logic [31:0]           commit_pc,
   output logic                  commit_exc,
   output logic [63:0]           retire_cnt
);

   localparam logic [1:0] SEL_ALU  = 2'd0;
   localparam logic [1:0] SEL_LOAD = 2'd1;
   localparam logic [1:0] SEL_PC4  = 2'd2;
   localparam logic [1:0] SEL_CSR  = 2'd3;

   // Handshake: a transfer happens on a posedge where valid and ready are both
   // high; valid never depends on ready, and the payload is stable while stalled.

   logic                  full_q;
   logic [31:0]           pc_q;
   logic [ADDR_WIDTH-1:0] rd_q;
   logic                  wb_en_q;
   logic [1:0]            sel_q;
   logic [DATA_WIDTH-1:0] alu_q;
   logic [DATA_WIDTH-1:0] raw_q;
   logic [2:0]            f3_q;
   logic [DATA_WIDTH-1:0] csr_q;
   logic [63:0]           cnt_q;

   logic                  fire_in;
   logic                  fire_out;
   logic [1:0]            off;
   logic [7:0]            byte_v;
   logic [15:0]           half_v;
   logic                  misaligned;
   logic                  illegal;
   logic [DATA_WIDTH-1:0] load_v;
   logic [DATA_WIDTH-1:0] wdata_v;

   assign in_ready     = !full_q || commit_ready;
   assign commit_valid = full_q;
   assign fire_in      = in_valid && in_ready;
   assign fire_out     = full_q && commit_ready;
   assign off          = alu_q[1:0];

   always_comb begin
      byte_v = raw_q[7:0];
      case (off)
         2'd0: byte_v = raw_q[7:0];
         2'd1: byte_v = raw_q[15:8];
         2'd2: byte_v = raw_q[23:16];
         2'd3: byte_v = raw_q[31:24];
         default: byte_v = raw_q[7:0];
      endcase
      half_v = off[1] ? raw_q[31:16] : raw_q[15:0];
   end

   always_comb begin
      misaligned = 1'b0;
      illegal    = 1'b0;
      load_v     = raw_q;
      case (f3_q)
         3'b000: load_v = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
         3'b100: load_v = {{(DATA_WIDTH-8){1'b0}}, byte_v};
         3'b001: begin
            load_v     = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
            misaligned = off[0];
         end
         3'b101: begin
            load_v     = {{(DATA_WIDTH-16){1'b0}}, half_v};
            misaligned = off[0];
         end
         3'b010: begin
            load_v     = raw_q;
            misaligned = (off != 2'd0);
         end
         default: illegal = 1'b1;
      endcase
   end

   always_comb begin
      wdata_v = alu_q;
      case (sel_q)
         SEL_ALU:  wdata_v = alu_q;
         SEL_LOAD: wdata_v = load_v;
         SEL_PC4:  wdata_v = pc_q + 32'd4;
         SEL_CSR:  wdata_v = csr_q;
         default:  wdata_v = alu_q;
      endcase
   end

   assign commit_exc = full_q && (sel_q == SEL_LOAD) && (misaligned || illegal);
   assign commit_pc  = pc_q;
   assign rf_waddr   = rd_q;
   assign rf_wdata   = wdata_v;
   assign rf_wen     = fire_out && wb_en_q && (rd_q != '0) && !commit_exc;
   assign retire_cnt = cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q  <= 1'b0;
         pc_q    <= '0;
         rd_q    <= '0;
         wb_en_q <= 1'b0;
         sel_q   <= '0;
         alu_q   <= '0;
         raw_q   <= '0;
         f3_q    <= '0;
         csr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         if (fire_out && !commit_exc) cnt_q <= cnt_q + 64'd1;
         // A simultaneous accept and retire keeps the buffer full with the new entry.
         if (fire_in) begin
            full_q  <= 1'b1;
            pc_q    <= in_pc;
            rd_q    <= in_rd;
            wb_en_q <= in_wb_en;
            sel_q   <= in_wb_sel;
            alu_q   <= in_alu_res;
            raw_q   <= in_load_raw;
            f3_q    <= in_funct3;
            csr_q   <= in_csr_rdata;
         end else if (fire_out) begin
            full_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_23060061_wbu.sv
// Bench for ysyx_23060061_wbu: directed cases from the test plan, then random
// traffic compared cycle by cycle against a behavioural buffer model.
module tb_ysyx_23060061_wbu;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [4:0]  in_rd;
   logic        in_wb_en;
   logic [1:0]  in_wb_sel;
   logic [31:0] in_alu_res;
   logic [31:0] in_load_raw;
   logic [2:0]  in_funct3;
   logic [31:0] in_csr_rdata;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        commit_valid;
   logic        commit_ready;
   logic [31:0] commit_pc;
   logic        commit_exc;
   logic [63:0] retire_cnt;

   ysyx_23060061_wbu #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_rd(in_rd),
      .in_wb_en(in_wb_en), .in_wb_sel(in_wb_sel), .in_alu_res(in_alu_res),
      .in_load_raw(in_load_raw), .in_funct3(in_funct3), .in_csr_rdata(in_csr_rdata),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .commit_valid(commit_valid), .commit_ready(commit_ready),
      .commit_pc(commit_pc), .commit_exc(commit_exc), .retire_cnt(retire_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        wb_en;
      logic [1:0]  sel;
      logic [31:0] alu;
      logic [31:0] raw;
      logic [2:0]  f3;
      logic [31:0] csr;
   } instr_t;

   int          n_checks = 0;
   int          n_errors = 0;
   int          wr_seen  = 0;
   bit          m_full;
   instr_t      m_ins;
   logic [63:0] m_cnt;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit m_fault(input instr_t i);
      int unsigned off;
      off = i.alu % 4;
      if (i.sel != 2'd1) return 1'b0;
      case (i.f3)
         3'd0, 3'd4: return 1'b0;
         3'd1, 3'd5: return (off % 2) != 0;
         3'd2:       return off != 0;
         default:    return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] m_value(input instr_t i);
      int unsigned off, b, h;
      off = i.alu % 4;
      b   = (i.raw >> (8 * off)) % 256;
      h   = (i.raw >> (16 * (off / 2))) % 65536;
      case (i.sel)
         2'd0: return i.alu;
         2'd2: return i.pc + 32'd4;
         2'd3: return i.csr;
         default: begin
            case (i.f3)
               3'd0: return (b >= 128) ? 32'(b + 32'hFFFF_FF00) : 32'(b);
               3'd4: return 32'(b);
               3'd1: return (h >= 32768) ? 32'(h + 32'hFFFF_0000) : 32'(h);
               3'd5: return 32'(h);
               default: return i.raw;
            endcase
         end
      endcase
   endfunction

   function automatic instr_t cur_input();
      instr_t i;
      i.pc = in_pc; i.rd = in_rd; i.wb_en = in_wb_en; i.sel = in_wb_sel;
      i.alu = in_alu_res; i.raw = in_load_raw; i.f3 = in_funct3; i.csr = in_csr_rdata;
      return i;
   endfunction

   // One clock: compare all outputs with the model at negedge, then advance the model.
   task automatic step();
      bit exp_exc, exp_wen, fin, fout;
      @(negedge clk);
      exp_exc = m_full && m_fault(m_ins);
      exp_wen = m_full && commit_ready && m_ins.wb_en && (m_ins.rd != 0) && !exp_exc;
      check("commit_valid", 64'(commit_valid), 64'(m_full));
      check("in_ready", 64'(in_ready), 64'(!m_full || commit_ready));
      check("commit_pc", 64'(commit_pc), 64'(m_ins.pc));
      check("commit_exc", 64'(commit_exc), 64'(exp_exc));
      check("rf_wen", 64'(rf_wen), 64'(exp_wen));
      check("rf_waddr", 64'(rf_waddr), 64'(m_ins.rd));
      check("retire_cnt", retire_cnt, m_cnt);
      if (exp_wen) check("rf_wdata", 64'(rf_wdata), 64'(m_value(m_ins)));
      if (rf_wen) wr_seen++;
      @(posedge clk);
      if (rst) begin
         m_full = 1'b0;
         m_ins  = '{default: '0};
         m_cnt  = '0;
      end else begin
         fout = m_full && commit_ready;
         fin  = in_valid && (!m_full || commit_ready);
         if (fout && !m_fault(m_ins)) m_cnt = m_cnt + 1;
         if (fin) begin
            m_ins  = cur_input();
            m_full = 1'b1;
         end else if (fout) begin
            m_full = 1'b0;
         end
      end
      #1;
   endtask

   task automatic drive(input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] alu,
                        input logic [31:0] raw, input logic [31:0] pc, input logic [4:0] rd);
      in_valid = 1'b1; in_wb_sel = sel; in_funct3 = f3; in_alu_res = alu;
      in_load_raw = raw; in_pc = pc; in_rd = rd; in_wb_en = 1'b1;
      in_csr_rdata = 32'hC5C5_0000 ^ pc;
   endtask

   // Accept one instruction, then look at the buffered result against a constant.
   task automatic issue_chk(input string tag, input logic [1:0] sel, input logic [2:0] f3,
                            input logic [31:0] alu, input logic [31:0] raw, input logic [31:0] pc,
                            input logic [4:0] rd, input logic [31:0] exp_wdata, input bit exp_exc);
      commit_ready = 1'b1;
      drive(sel, f3, alu, raw, pc, rd);
      step();
      in_valid = 1'b0;
      check({tag, "_valid"}, 64'(commit_valid), 64'd1);
      check({tag, "_exc"}, 64'(commit_exc), 64'(exp_exc));
      check({tag, "_wen"}, 64'(rf_wen), 64'(!exp_exc && rd != 0));
      if (!exp_exc) check({tag, "_wdata"}, 64'(rf_wdata), 64'(exp_wdata));
      step();
   endtask

   logic [63:0] cnt_before;
   int          wr_before;

   initial begin
      rst = 1'b1; commit_ready = 1'b0;
      drive(2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0);
      in_valid = 1'b0;
      m_full = 1'b0; m_ins = '{default: '0}; m_cnt = '0;
      @(posedge clk); #1;
      step();
      rst = 1'b0;
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_rf_wdata", 64'(rf_wdata), 64'd0);
      step();

      // ALU writeback and counter
      cnt_before = m_cnt;
      issue_chk("alu", 2'd0, 3'd0, 32'h1234, 32'h0, 32'h8000_0100, 5'd5, 32'h1234, 1'b0);
      check("alu_cnt", retire_cnt, cnt_before + 1);

      // Load shaping
      issue_chk("lb3",  2'd1, 3'b000, 32'h1003, 32'h80FF7F01, 32'h200, 5'd6, 32'hFFFFFF80, 1'b0);
      issue_chk("lbu1", 2'd1, 3'b100, 32'h1001, 32'h80FF7F01, 32'h204, 5'd7, 32'h0000007F, 1'b0);
      issue_chk("lh2",  2'd1, 3'b001, 32'h1002, 32'h80FF7F01, 32'h208, 5'd8, 32'hFFFF80FF, 1'b0);
      issue_chk("lhu2", 2'd1, 3'b101, 32'h1002, 32'h80FF7F01, 32'h20C, 5'd9, 32'h000080FF, 1'b0);
      issue_chk("lw0",  2'd1, 3'b010, 32'h1000, 32'h80FF7F01, 32'h210, 5'd10, 32'h80FF7F01, 1'b0);

      // Faults commit but do not write or count
      cnt_before = m_cnt;
      issue_chk("lw_mis", 2'd1, 3'b010, 32'h1002, 32'h1, 32'h300, 5'd11, 32'h0, 1'b1);
      issue_chk("lh_mis", 2'd1, 3'b001, 32'h1001, 32'h1, 32'h304, 5'd12, 32'h0, 1'b1);
      issue_chk("f3_011", 2'd1, 3'b011, 32'h1000, 32'h1, 32'h308, 5'd13, 32'h0, 1'b1);
      check("fault_cnt", retire_cnt, cnt_before);

      // x0 is never written but still retires; PC+4 wraps
      cnt_before = m_cnt;
      issue_chk("x0", 2'd0, 3'd0, 32'hDEAD, 32'h0, 32'h400, 5'd0, 32'hDEAD, 1'b0);
      check("x0_cnt", retire_cnt, cnt_before + 1);
      issue_chk("pc4", 2'd2, 3'd0, 32'h0, 32'h0, 32'hFFFF_FFFC, 5'd1, 32'h0, 1'b0);

      // Backpressure: second instruction waits until the first retires
      wr_before = wr_seen;
      commit_ready = 1'b0;
      drive(2'd0, 3'd0, 32'hAAAA_0001, 32'h0, 32'h500, 5'd20);
      step();
      drive(2'd0, 3'd0, 32'hBBBB_0002, 32'h0, 32'h504, 5'd21);
      for (int k = 0; k < 3; k++) begin
         step();
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check("bp_hold_pc", 64'(commit_pc), 64'h500);
      end
      commit_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check("bp_second_pc", 64'(commit_pc), 64'h504);
      step();
      check("bp_writes", 64'(wr_seen - wr_before), 64'd2);

      // Reset while stalled with a full buffer
      commit_ready = 1'b0;
      drive(2'd0, 3'd0, 32'h77, 32'h0, 32'h600, 5'd3);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0; in_valid = 1'b0;
      check("rst_commit_valid", 64'(commit_valid), 64'd0);
      check("rst_retire_cnt", retire_cnt, 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      step();

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         in_valid     = ($urandom_range(0, 3) != 0);
         commit_ready = ($urandom_range(0, 9) < 7);
         in_pc        = $urandom() & 32'hFFFF_FFFC;
         in_rd        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         in_wb_en     = ($urandom_range(0, 7) != 0);
         in_wb_sel    = 2'($urandom_range(0, 3));
         in_alu_res   = $urandom();
         in_load_raw  = $urandom();
         in_funct3    = 3'($urandom_range(0, 7));
         in_csr_rdata = $urandom();
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
